operand_pipeline: RTL and testbench
===================================

OPERAND_PIPELINE -- requirements
Module: operand_pipeline

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width in bits.
REQ-002 Ports (the reset is asynchronous and active-high):
  - clk  in  1  single clock; all state updates on its rising edge.
  - reset  in  1  asynchronous, active-high.
  - RegWriteD  in  1  decode-stage instruction writes a register.
  - MemToRegD  in  1  decode-stage result comes from memory.
  - RsD, RtD, RdD  in  3 each  decode-stage source and destination register numbers.
  - RD1D, RD2D  in  WIDTH each  decode-stage register-file read data.
  - FlushE  in  1  hazard-control bubble request for the E stage.
  - ForwardA, ForwardB  in  2 each  operand select: 00 = register data, 01 = W-stage data, 10 = M-stage data.
  - ALUResultE  in  WIDTH  execute-stage ALU output.
  - ReadDataM  in  WIDTH  data-memory read data for the M stage.
  - A, B  out  3 each  RsE and RtE, sent to hazard control.
  - WB2, RegWriteM  out  3, 1  M-stage destination register and write enable.
  - WB3, RegWriteW  out  3, 1  W-stage destination register and write enable.
  - SrcAE, SrcBE  out  WIDTH each  forwarded E-stage operands.
  - ALUOutM  out  WIDTH  M-stage ALU result.
  - ResultW  out  WIDTH  write-back data.
  - BubbleCount  out  8  number of flushed E slots.

Function
REQ-003 The block SHALL hold three pipeline registers, E, M and W, all of which update on every rising edge of clk.
REQ-004 The E register SHALL capture RegWriteD, MemToRegD, RsD, RtD, RdD, RD1D and RD2D when FlushE=0.
REQ-005 When FlushE=1, the E register SHALL load a bubble: all control fields 0, all register numbers 0, all data 0.
REQ-006 FlushE SHALL take precedence over any simultaneous decode input.
REQ-007 The block SHALL have no stall input; upstream stages hold D, and E still advances.
REQ-008 M SHALL capture from E: RegWrite, MemToReg and Rd; ALUOutM SHALL capture ALUResultE.
REQ-009 W SHALL capture from M: RegWrite and Rd; ResultW SHALL capture ReadDataM when MemToRegM=1, otherwise ALUOutM.
REQ-010 Latency: an instruction in D at cycle n SHALL occupy E at n+1, M at n+2 and W at n+3.
REQ-011 The outputs SHALL be driven as: A=RsE, B=RtE, WB2=RdM, WB3=RdW.
REQ-012 RegWriteM SHALL equal the M-stage RegWrite bit.
REQ-013 RegWriteW SHALL equal the W-stage RegWrite AND (RdW != 0), so register 0 is never written or forwarded from W.
REQ-014 SrcAE SHALL be combinational from E state and the forward selects:
  - ForwardA=10: ALUOutM.
  - ForwardA=01: ResultW.
  - ForwardA=00 or 11: RD1E.
REQ-015 SrcBE SHALL follow the same rule as REQ-014, using ForwardB and RD2E.
REQ-016 BubbleCount SHALL increment by 1 on each edge where FlushE=1.
REQ-017 BubbleCount SHALL saturate at 255 and SHALL NOT wrap.
REQ-018 Any X on ForwardA or ForwardB SHALL NOT corrupt the pipeline state, because the select affects only the combinational operands.

Reset
REQ-019 While reset=1, the E, M and W registers SHALL be cleared immediately and asynchronously, independent of clk.
REQ-020 While reset=1, all outputs SHALL be 0, and BubbleCount SHALL be 0.
REQ-021 On reset deassertion, the first rising edge SHALL load E from the D inputs, subject to FlushE.
REQ-022 A reset asserted mid-operation SHALL discard all in-flight instructions; none SHALL reach W afterward.

Verification
REQ-023 Straight flow: RegWriteD=1, RdD=3, ALUResultE=16'h1234 while in E, MemToReg=0.
  - Required: RegWriteM=1 and WB2=3 one cycle after E; ResultW=16'h1234, RegWriteW=1 and WB3=3 one further cycle later.
REQ-024 Flush: FlushE=1 with RegWriteD=1, RdD=5.
  - Required: next cycle A=0, B=0, RegWrite in E=0; two cycles later RegWriteM=0; BubbleCount=1.
REQ-025 Forwarding: ALUOutM=16'hAAAA, ResultW=16'h5555, RD1E=16'h0001.
  - Required: ForwardA=10 gives SrcAE=AAAA; 01 gives 5555; 00 gives 0001; 11 gives 0001.
REQ-026 Register 0: an instruction with RdD=0 and RegWriteD=1 SHALL show RegWriteM=1 in M but RegWriteW=0 in W.
REQ-027 Load path: MemToRegD=1, ReadDataM=16'hBEEF during M.
  - Required: ResultW=BEEF in W regardless of ALUOutM.
REQ-028 Saturation and reset: hold FlushE=1 for 300 cycles, then pulse reset mid-cycle.
  - Required: BubbleCount=255 before the pulse, then 0 immediately and asynchronously.
  - Required: RegWriteM=0 and RegWriteW=0 immediately, with no instruction retiring in the following 2 cycles.

Source files
------------

// File: rtl/operand_pipeline.sv
// Execute/memory/write-back operand pipeline: E, M and W stage registers,
// E-stage operand forwarding and a saturating count of flushed E slots.
module operand_pipeline #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteD,
    input  logic             MemToRegD,
    input  logic [2:0]       RsD,
    input  logic [2:0]       RtD,
    input  logic [2:0]       RdD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic             FlushE,
    input  logic [1:0]       ForwardA,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] ALUResultE,
    input  logic [WIDTH-1:0] ReadDataM,
    output logic [2:0]       A,
    output logic [2:0]       B,
    output logic [2:0]       WB2,
    output logic             RegWriteM,
    output logic [2:0]       WB3,
    output logic             RegWriteW,
    output logic [WIDTH-1:0] SrcAE,
    output logic [WIDTH-1:0] SrcBE,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] ResultW,
    output logic [7:0]       BubbleCount
);

    logic             regWriteE;
    logic             memToRegE;
    logic [2:0]       rsE;
    logic [2:0]       rtE;
    logic [2:0]       rdE;
    logic [WIDTH-1:0] rd1E;
    logic [WIDTH-1:0] rd2E;

    logic             regWriteMReg;
    logic             memToRegM;
    logic [2:0]       rdM;
    logic [WIDTH-1:0] aluOutMReg;

    logic             regWriteWReg;
    logic [2:0]       rdW;
    logic [WIDTH-1:0] resultWReg;

    logic [7:0]       bubbleCountReg;

    // A flush overrides the decode inputs and loads an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteE <= 1'b0;
            memToRegE <= 1'b0;
            rsE       <= '0;
            rtE       <= '0;
            rdE       <= '0;
            rd1E      <= '0;
            rd2E      <= '0;
        end else if (FlushE) begin
            regWriteE <= 1'b0;
            memToRegE <= 1'b0;
            rsE       <= '0;
            rtE       <= '0;
            rdE       <= '0;
            rd1E      <= '0;
            rd2E      <= '0;
        end else begin
            regWriteE <= RegWriteD;
            memToRegE <= MemToRegD;
            rsE       <= RsD;
            rtE       <= RtD;
            rdE       <= RdD;
            rd1E      <= RD1D;
            rd2E      <= RD2D;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteMReg <= 1'b0;
            memToRegM    <= 1'b0;
            rdM          <= '0;
            aluOutMReg   <= '0;
        end else begin
            regWriteMReg <= regWriteE;
            memToRegM    <= memToRegE;
            rdM          <= rdE;
            aluOutMReg   <= ALUResultE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regWriteWReg <= 1'b0;
            rdW          <= '0;
            resultWReg   <= '0;
        end else begin
            regWriteWReg <= regWriteMReg;
            rdW          <= rdM;
            resultWReg   <= memToRegM ? ReadDataM : aluOutMReg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubbleCountReg <= '0;
        end else if (FlushE && (bubbleCountReg != 8'hFF)) begin
            bubbleCountReg <= bubbleCountReg + 8'd1;
        end
    end

    // Unknown or reserved selects fall through to the register operand.
    always_comb begin
        SrcAE = rd1E;
        case (ForwardA)
            2'b10:   SrcAE = aluOutMReg;
            2'b01:   SrcAE = resultWReg;
            default: SrcAE = rd1E;
        endcase
    end

    always_comb begin
        SrcBE = rd2E;
        case (ForwardB)
            2'b10:   SrcBE = aluOutMReg;
            2'b01:   SrcBE = resultWReg;
            default: SrcBE = rd2E;
        endcase
    end

    assign A           = rsE;
    assign B           = rtE;
    assign WB2         = rdM;
    assign RegWriteM   = regWriteMReg;
    assign WB3         = rdW;
    // Register 0 is hardwired, so a W-stage write to it is suppressed here.
    assign RegWriteW   = regWriteWReg && (rdW != 3'd0);
    assign ALUOutM     = aluOutMReg;
    assign ResultW     = resultWReg;
    assign BubbleCount = bubbleCountReg;

endmodule

// File: tb/tb_operand_pipeline.sv
// Randomized and directed bench for operand_pipeline; a per-cycle expectation
// queue is filled by the stimulus and drained by an independent monitor.
module tb_operand_pipeline;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        RegWriteD, MemToRegD;
    logic [2:0]  RsD, RtD, RdD;
    logic [15:0] RD1D, RD2D;
    logic        FlushE;
    logic [1:0]  ForwardA, ForwardB;
    logic [15:0] ALUResultE, ReadDataM;
    logic [2:0]  A, B, WB2, WB3;
    logic        RegWriteM, RegWriteW;
    logic [15:0] SrcAE, SrcBE, ALUOutM, ResultW;
    logic [7:0]  BubbleCount;

    always #10 clk = ~clk;

    operand_pipeline #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .RegWriteD(RegWriteD), .MemToRegD(MemToRegD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .RD1D(RD1D), .RD2D(RD2D),
        .FlushE(FlushE), .ForwardA(ForwardA), .ForwardB(ForwardB),
        .ALUResultE(ALUResultE), .ReadDataM(ReadDataM),
        .A(A), .B(B), .WB2(WB2), .RegWriteM(RegWriteM),
        .WB3(WB3), .RegWriteW(RegWriteW),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUOutM(ALUOutM), .ResultW(ResultW),
        .BubbleCount(BubbleCount)
    );

    // One instruction per issue cycle; alu/mem are what the datapath supplied
    // while that instruction sat in E and M respectively.
    typedef struct packed {
        logic        rw;
        logic        m2r;
        logic [2:0]  rs, rt, rd;
        logic [15:0] d1, d2, alu, mem;
    } instT;

    typedef struct {
        logic [2:0]  a, b, wb2, wb3;
        logic        rwm, rww;
        logic [15:0] srcA, srcB, aluOut, result;
        logic [7:0]  bub;
    } expT;

    instT hist [0:2047];
    int   c;
    int   nFlush;
    expT  expQ [$];
    int   nChk = 0;
    int   nErr = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic instT at(input int i);
        if (i < 0) return '0;
        return hist[i];
    endfunction

    function automatic logic [15:0] resultOf(input instT x);
        return x.m2r ? x.mem : x.alu;
    endfunction

    function automatic logic [15:0] pick(input logic [1:0] s, input logic [15:0] r,
                                         input logic [15:0] m, input logic [15:0] w);
        if (s == 2'b10) return m;
        if (s == 2'b01) return w;
        return r;
    endfunction

    function automatic instT mk(input logic rw, input logic m2r, input logic [2:0] rs,
                                input logic [2:0] rt, input logic [2:0] rd,
                                input logic [15:0] d1, input logic [15:0] d2);
        instT t;
        t = '0;
        t.rw = rw; t.m2r = m2r; t.rs = rs; t.rt = rt; t.rd = rd; t.d1 = d1; t.d2 = d2;
        return t;
    endfunction

    function automatic instT rndInst();
        return mk(1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                  3'($urandom_range(7)), 3'($urandom_range(7)),
                  16'($urandom), 16'($urandom));
    endfunction

    // Drive cycle c's inputs and record what the outputs must show during it.
    task automatic driveCycle(input instT d, input bit fl, input logic [15:0] alu,
                              input logic [15:0] mem, input logic [1:0] fa, input logic [1:0] fb);
        instT e, m, w;
        expT  x;
        RegWriteD = d.rw; MemToRegD = d.m2r;
        RsD = d.rs; RtD = d.rt; RdD = d.rd; RD1D = d.d1; RD2D = d.d2;
        FlushE = fl; ALUResultE = alu; ReadDataM = mem; ForwardA = fa; ForwardB = fb;
        hist[c] = fl ? instT'(0) : d;
        hist[c].alu = '0;
        hist[c].mem = '0;
        hist[c-1].alu = alu;
        hist[c-2].mem = mem;
        e = at(c-1); m = at(c-2); w = at(c-3);
        x.a = e.rs; x.b = e.rt;
        x.wb2 = m.rd; x.rwm = m.rw; x.aluOut = m.alu;
        x.wb3 = w.rd; x.rww = w.rw && (w.rd != 3'd0); x.result = resultOf(w);
        x.srcA = pick(fa, e.d1, m.alu, resultOf(w));
        x.srcB = pick(fb, e.d2, m.alu, resultOf(w));
        x.bub = (nFlush > 255) ? 8'd255 : 8'(nFlush);
        expQ.push_back(x);
        if (fl) nFlush++;
        c++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doCycle(input instT d, input bit fl, input logic [15:0] alu,
                           input logic [15:0] mem, input logic [1:0] fa, input logic [1:0] fb);
        driveCycle(d, fl, alu, mem, fa, fb);
        step();
    endtask

    task automatic modelReset();
        hist[c-1] = '0; hist[c-2] = '0; hist[c-3] = '0;
        nFlush = 0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_A"}, 32'(A), 0);
        check({tag, "_B"}, 32'(B), 0);
        check({tag, "_WB2"}, 32'(WB2), 0);
        check({tag, "_RegWriteM"}, 32'(RegWriteM), 0);
        check({tag, "_WB3"}, 32'(WB3), 0);
        check({tag, "_RegWriteW"}, 32'(RegWriteW), 0);
        check({tag, "_SrcAE"}, 32'(SrcAE), 0);
        check({tag, "_SrcBE"}, 32'(SrcBE), 0);
        check({tag, "_ALUOutM"}, 32'(ALUOutM), 0);
        check({tag, "_ResultW"}, 32'(ResultW), 0);
        check({tag, "_BubbleCount"}, 32'(BubbleCount), 0);
    endtask

    always @(negedge clk) begin
        if (!reset && expQ.size() > 0) begin
            expT x;
            x = expQ.pop_front();
            check("A", 32'(A), 32'(x.a));
            check("B", 32'(B), 32'(x.b));
            check("WB2", 32'(WB2), 32'(x.wb2));
            check("RegWriteM", 32'(RegWriteM), 32'(x.rwm));
            check("WB3", 32'(WB3), 32'(x.wb3));
            check("RegWriteW", 32'(RegWriteW), 32'(x.rww));
            check("ALUOutM", 32'(ALUOutM), 32'(x.aluOut));
            check("ResultW", 32'(ResultW), 32'(x.result));
            check("SrcAE", 32'(SrcAE), 32'(x.srcA));
            check("SrcBE", 32'(SrcBE), 32'(x.srcB));
            check("BubbleCount", 32'(BubbleCount), 32'(x.bub));
        end
    end

    instT        nop;
    logic [1:0]  fsel [4];
    logic [15:0] fexp [4];

    initial begin
        for (int i = 0; i < 2048; i++) hist[i] = '0;
        nop = '0;
        c = 3;
        nFlush = 0;
        fsel = '{2'b10, 2'b01, 2'b00, 2'b11};
        fexp = '{16'hAAAA, 16'h5555, 16'h0001, 16'h0001};
        RegWriteD = 1'b1; MemToRegD = 1'b0; RsD = 3'd1; RtD = 3'd2; RdD = 3'd3;
        RD1D = 16'h1111; RD2D = 16'h2222; FlushE = 1'b0;
        ForwardA = 2'b00; ForwardB = 2'b00; ALUResultE = 16'h3333; ReadDataM = 16'h4444;

        #2 reset = 1'b1;
        #2 checkAllZero("rst_init");
        @(posedge clk);
        #1 reset = 1'b0;

        // Straight flow through to write-back.
        driveCycle(mk(1'b1, 1'b0, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022), 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        step();
        doCycle(nop, 1'b0, 16'h1234, 16'($urandom), 2'b00, 2'b00);
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("flow_RegWriteM", 32'(RegWriteM), 1);
        check("flow_WB2", 32'(WB2), 3);
        step();
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("flow_ResultW", 32'(ResultW), 32'h1234);
        check("flow_RegWriteW", 32'(RegWriteW), 1);
        check("flow_WB3", 32'(WB3), 3);
        step();

        // Flush beats a live decode instruction.
        doCycle(mk(1'b1, 1'b0, 3'd4, 3'd6, 3'd5, 16'h0555, 16'h0666), 1'b1, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("flush_A", 32'(A), 0);
        check("flush_B", 32'(B), 0);
        check("flush_BubbleCount", 32'(BubbleCount), 1);
        step();
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("flush_RegWriteM", 32'(RegWriteM), 0);
        step();

        // Forwarding selects with fixed M, W and register operands.
        doCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        doCycle(nop, 1'b0, 16'h5555, 16'($urandom), 2'b00, 2'b00);
        doCycle(mk(1'b0, 1'b0, 3'd1, 3'd2, 3'd0, 16'h0001, 16'h0002), 1'b0, 16'hAAAA, 16'($urandom), 2'b00, 2'b00);
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ForwardA = fsel[i];
            #1 check($sformatf("fwd_SrcAE_sel%0d", i), 32'(SrcAE), 32'(fexp[i]));
        end
        ForwardA = 2'b00;
        step();

        // Register 0 destination never writes back.
        doCycle(mk(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 16'h0007, 16'h0008), 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        doCycle(nop, 1'b0, 16'h0F0F, 16'($urandom), 2'b00, 2'b00);
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("r0_RegWriteM", 32'(RegWriteM), 1);
        step();
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("r0_RegWriteW", 32'(RegWriteW), 0);
        step();

        // Load result comes from memory, not the ALU.
        doCycle(mk(1'b1, 1'b1, 3'd0, 3'd0, 3'd6, 16'h0000, 16'h0000), 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        doCycle(nop, 1'b0, 16'h7777, 16'($urandom), 2'b00, 2'b00);
        doCycle(nop, 1'b0, 16'($urandom), 16'hBEEF, 2'b00, 2'b00);
        driveCycle(nop, 1'b0, 16'($urandom), 16'($urandom), 2'b00, 2'b00);
        @(negedge clk); #1;
        check("load_ResultW", 32'(ResultW), 32'hBEEF);
        check("load_RegWriteW", 32'(RegWriteW), 1);
        step();

        for (int i = 0; i < 400; i++) begin
            doCycle(rndInst(), ($urandom_range(7) == 0), 16'($urandom), 16'($urandom),
                    2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        // Saturation, then an asynchronous mid-cycle reset.
        for (int i = 0; i < 300; i++) begin
            doCycle(rndInst(), 1'b1, 16'($urandom), 16'($urandom),
                    2'($urandom_range(3)), 2'($urandom_range(3)));
        end
        driveCycle(mk(1'b1, 1'b0, 3'd1, 3'd2, 3'd4, 16'h0101, 16'h0202), 1'b0, 16'($urandom), 16'($urandom), 2'b01, 2'b10);
        @(negedge clk); #2;
        check("sat_BubbleCount", 32'(BubbleCount), 255);
        reset = 1'b1;
        #1 checkAllZero("rst_mid");
        step();
        checkAllZero("rst_held");
        reset = 1'b0;
        modelReset();
        for (int i = 0; i < 6; i++) begin
            doCycle(mk(1'b1, 1'b0, 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7, 1)),
                       16'($urandom), 16'($urandom)),
                    1'b0, 16'($urandom), 16'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)));
        end

        @(negedge clk); #1;
        check("queue_drained", 32'(expQ.size()), 0);
        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
